// File: rtl/fb_draw_pkg.sv
// Shared constants, opcode/state enums and the captured-command record for the
// frame buffer draw engine.
package fb_draw_pkg;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 180;
    localparam int unsigned FB_SIZE   = $clog2(FB_WIDTH * FB_HEIGHT);
    localparam int unsigned X_W       = $clog2(FB_WIDTH + 1);
    localparam int unsigned Y_W       = $clog2(FB_HEIGHT + 1);

    typedef enum logic {OP_FILL = 1'b0, OP_SWAP = 1'b1} fb_op_t;

    typedef enum logic [1:0] {StIdle, StSetup, StFill, StWaitVsync} fb_state_t;

    typedef struct packed {
        fb_op_t         op;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic [15:0]    color;
    } fb_cmd_t;

    // y * 320 as (y << 8) + (y << 6)
    function automatic logic [FB_SIZE-1:0] row_offset(input logic [Y_W-1:0] y);
        return FB_SIZE'({y, 8'b0}) + FB_SIZE'({y, 6'b0});
    endfunction

endpackage

// File: rtl/fb_draw_engine.sv
// Frame buffer write-side initiator: clipped rectangle fills at one pixel per
// cycle and tear-free buffer swaps aligned to vsync.
module fb_draw_engine
    import fb_draw_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic               cmd_op_in,
    input  logic [X_W-1:0]     cmd_x_in,
    input  logic [Y_W-1:0]     cmd_y_in,
    input  logic [X_W-1:0]     cmd_w_in,
    input  logic [Y_W-1:0]     cmd_h_in,
    input  logic [15:0]        cmd_color_in,
    input  logic               vsync_in,
    output logic               cmd_done_out,
    output logic [15:0]        write_data_out,
    output logic [FB_SIZE-1:0] write_addr_out,
    output logic               write_enable_out,
    output logic               swap_buffer_out
);

    fb_state_t          state;
    fb_cmd_t            cmd;
    logic [X_W:0]       x_end;
    logic [Y_W:0]       y_end;
    logic [X_W-1:0]     cur_x;
    logic [Y_W-1:0]     cur_y;
    logic [FB_SIZE-1:0] row_base;

    logic [X_W:0]       x_sum, clip_x_end;
    logic [Y_W:0]       y_sum, clip_y_end;
    logic               empty, first_last;
    logic               wrap, next_last;
    logic [X_W-1:0]     next_x;
    logic [Y_W-1:0]     next_y;
    logic [FB_SIZE-1:0] next_row_base;

    // Clipping, evaluated while in SETUP on the captured command.
    always_comb begin
        x_sum      = {1'b0, cmd.x} + {1'b0, cmd.w};
        y_sum      = {1'b0, cmd.y} + {1'b0, cmd.h};
        clip_x_end = (x_sum > (X_W+1)'(FB_WIDTH)) ? (X_W+1)'(FB_WIDTH) : x_sum;
        clip_y_end = (y_sum > (Y_W+1)'(FB_HEIGHT)) ? (Y_W+1)'(FB_HEIGHT) : y_sum;
        empty      = (cmd.w == '0) || (cmd.h == '0) ||
                     (cmd.x >= X_W'(FB_WIDTH)) || (cmd.y >= Y_W'(FB_HEIGHT));
        first_last = ({1'b0, cmd.x} == clip_x_end - 1'b1) &&
                     ({1'b0, cmd.y} == clip_y_end - 1'b1);
    end

    // Next pixel after the one currently on the write port.
    always_comb begin
        wrap          = ({1'b0, cur_x} == x_end - 1'b1);
        next_x        = wrap ? cmd.x : cur_x + 1'b1;
        next_y        = wrap ? cur_y + 1'b1 : cur_y;
        next_row_base = wrap ? row_base + FB_SIZE'(FB_WIDTH) : row_base;
        next_last     = ({1'b0, next_x} == x_end - 1'b1) &&
                        ({1'b0, next_y} == y_end - 1'b1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= StIdle;
            cmd              <= '0;
            x_end            <= '0;
            y_end            <= '0;
            cur_x            <= '0;
            cur_y            <= '0;
            row_base         <= '0;
            cmd_ready_out    <= 1'b1;
            cmd_done_out     <= 1'b0;
            write_data_out   <= '0;
            write_addr_out   <= '0;
            write_enable_out <= 1'b0;
            swap_buffer_out  <= 1'b0;
        end else begin
            cmd_done_out     <= 1'b0;
            write_enable_out <= 1'b0;
            swap_buffer_out  <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_valid_in && cmd_ready_out) begin
                        cmd.op        <= fb_op_t'(cmd_op_in);
                        cmd.x         <= cmd_x_in;
                        cmd.y         <= cmd_y_in;
                        cmd.w         <= cmd_w_in;
                        cmd.h         <= cmd_h_in;
                        cmd.color     <= cmd_color_in;
                        cmd_ready_out <= 1'b0;
                        state         <= (fb_op_t'(cmd_op_in) == OP_SWAP) ? StWaitVsync : StSetup;
                    end
                end
                StSetup: begin
                    x_end <= clip_x_end;
                    y_end <= clip_y_end;
                    // Empty rectangles pass through FILL only to emit the done pulse.
                    state <= StFill;
                    if (empty) begin
                        cmd_done_out <= 1'b1;
                    end else begin
                        cur_x            <= cmd.x;
                        cur_y            <= cmd.y;
                        row_base         <= row_offset(cmd.y);
                        write_addr_out   <= row_offset(cmd.y) + FB_SIZE'(cmd.x);
                        write_data_out   <= cmd.color;
                        write_enable_out <= 1'b1;
                        cmd_done_out     <= first_last;
                    end
                end
                StFill: begin
                    if (cmd_done_out) begin
                        state         <= StIdle;
                        cmd_ready_out <= 1'b1;
                    end else begin
                        cur_x            <= next_x;
                        cur_y            <= next_y;
                        row_base         <= next_row_base;
                        write_addr_out   <= next_row_base + FB_SIZE'(next_x);
                        write_enable_out <= 1'b1;
                        cmd_done_out     <= next_last;
                    end
                end
                StWaitVsync: begin
                    if (cmd_done_out) begin
                        state         <= StIdle;
                        cmd_ready_out <= 1'b1;
                    end else if (vsync_in && cmd.op == OP_SWAP) begin
                        swap_buffer_out <= 1'b1;
                        cmd_done_out    <= 1'b1;
                    end
                end
                default: begin
                    state         <= StIdle;
                    cmd_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_draw_engine.sv
// Directed self-checking bench for fb_draw_engine: table of fill vectors plus
// hand-written swap, reset-abort and handshake sequences.
module tb_fb_draw_engine;
    import fb_draw_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_op = 1'b0;
    logic [X_W-1:0]     cmd_x = '0;
    logic [Y_W-1:0]     cmd_y = '0;
    logic [X_W-1:0]     cmd_w = '0;
    logic [Y_W-1:0]     cmd_h = '0;
    logic [15:0]        cmd_color = '0;
    logic               vsync = 1'b0;
    logic               done;
    logic [15:0]        wdata;
    logic [FB_SIZE-1:0] waddr;
    logic               we;
    logic               swap;

    fb_draw_engine dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .cmd_valid_in     (cmd_valid),
        .cmd_ready_out    (cmd_ready),
        .cmd_op_in        (cmd_op),
        .cmd_x_in         (cmd_x),
        .cmd_y_in         (cmd_y),
        .cmd_w_in         (cmd_w),
        .cmd_h_in         (cmd_h),
        .cmd_color_in     (cmd_color),
        .vsync_in         (vsync),
        .cmd_done_out     (done),
        .write_data_out   (wdata),
        .write_addr_out   (waddr),
        .write_enable_out (we),
        .swap_buffer_out  (swap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int got_addr[$];

    typedef struct {
        int x, y, w, h, color;
        int n, first, last;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int waitc = 0;
        while (!cmd_ready && waitc < 10) begin
            step();
            waitc++;
        end
        check({tag, " ready_before"}, int'(cmd_ready), 1);
    endtask

    // Relative cycle 0 is the accept cycle; writes are checked against a
    // row-major walk of the clipped rectangle.
    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input int color, input int n, input int first,
                            input int last, input string tag);
        int xe, ye, rw, count, bad, done_c, first_c, first_a, last_a, exp_a;
        bit done_we;
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = X_W'(x);
        cmd_y     = Y_W'(y);
        cmd_w     = X_W'(w);
        cmd_h     = Y_W'(h);
        cmd_color = 16'(color);
        step();
        cmd_valid = 1'b0;
        check({tag, " ready_in_setup"}, int'(cmd_ready), 0);
        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 180) ? 180 : y + h;
        rw = xe - x;
        count = 0; bad = 0; done_c = -1; first_c = -1; first_a = -1; last_a = -1;
        done_we = 1'b0;
        got_addr.delete();
        for (int c = 2; c < n + 12; c++) begin
            step();
            if (we) begin
                if (count == 0) begin
                    first_c = c;
                    first_a = int'(waddr);
                end
                if (rw > 0) begin
                    exp_a = (y + count / rw) * 320 + x + count % rw;
                    if (int'(waddr) != exp_a || int'(wdata) != color) bad++;
                end else begin
                    bad++;
                end
                got_addr.push_back(int'(waddr));
                last_a = int'(waddr);
                count++;
            end
            if (done) begin
                done_c  = c;
                done_we = we;
                break;
            end
        end
        check({tag, " write_count"}, count, n);
        check({tag, " done_cycle"}, done_c, (n > 0) ? n + 1 : 2);
        check({tag, " addr_data_seq_errors"}, bad, 0);
        if (n > 0) begin
            check({tag, " first_write_cycle"}, first_c, 2);
            check({tag, " first_addr"}, first_a, first);
            check({tag, " last_addr"}, last_a, last);
            check({tag, " done_with_last_write"}, int'(done_we), 1);
        end else begin
            check({tag, " done_without_write"}, int'(done_we), 0);
        end
        step();
        check({tag, " done_single_cycle"}, int'(done), 0);
        check({tag, " ready_after"}, int'(cmd_ready), 1);
        check({tag, " we_after"}, int'(we), 0);
        if (n > 0) check({tag, " addr_hold"}, int'(waddr), last);
    endtask

    task automatic run_swap();
        int swaps = 0;
        wait_ready("swap");
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        vsync     = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        vsync     = 1'b0;
        check("swap ready_in_wait", int'(cmd_ready), 0);
        for (int c = 1; c < 50; c++) begin
            if (swap || done) swaps++;
            step();
        end
        check("swap early_swap_or_done", swaps, 0);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check("swap pulse", int'(swap), 1);
        check("swap done_pulse", int'(done), 1);
        check("swap ready_during_done", int'(cmd_ready), 0);
        step();
        check("swap pulse_end", int'(swap), 0);
        check("swap done_end", int'(done), 0);
        check("swap ready_after", int'(cmd_ready), 1);
    endtask

    task automatic run_reset_mid_fill();
        int count = 0;
        int stray = 0;
        wait_ready("rst_fill");
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = X_W'(320);
        cmd_h     = Y_W'(180);
        cmd_color = 16'hF800;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && count < 100; c++) begin
            step();
            if (we) count++;
        end
        check("rst_fill writes_before_reset", count, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_fill we_after_reset", int'(we), 0);
        check("rst_fill ready_after_reset", int'(cmd_ready), 1);
        check("rst_fill done_after_reset", int'(done), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            if (we || done) stray++;
        end
        check("rst_fill no_activity_after_reset", stray, 0);
        run_fill(0, 0, 2, 2, 16'h00FF, 4, 0, 321, "post_reset_2x2");
    endtask

    // Second command held on the bus while the first is busy.
    task automatic run_handshake();
        int c, a_done, a_writes, ready_c, b_writes, b_first, b_done;
        wait_ready("hs");
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_x     = X_W'(0);
        cmd_y     = Y_W'(0);
        cmd_w     = X_W'(3);
        cmd_h     = Y_W'(1);
        cmd_color = 16'h1111;
        step();
        cmd_x     = X_W'(10);
        cmd_y     = Y_W'(1);
        cmd_w     = X_W'(2);
        cmd_color = 16'h2222;
        c = 1; a_done = -1; a_writes = 0; ready_c = -1;
        while (c < 30) begin
            if (cmd_ready) begin
                ready_c = c;
                break;
            end
            if (we) a_writes++;
            if (done) a_done = c;
            step();
            c++;
        end
        check("hs first_done_cycle", a_done, 4);
        check("hs first_writes", a_writes, 3);
        check("hs ready_return_cycle", ready_c, 5);
        step();
        cmd_valid = 1'b0;
        check("hs second_accepted", int'(cmd_ready), 0);
        b_writes = 0; b_first = -1; b_done = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (we) begin
                if (b_writes == 0) b_first = int'(waddr);
                if (int'(wdata) != 16'h2222) b_writes += 100;
                b_writes++;
            end
            if (done) begin
                b_done = k + 1;
                break;
            end
        end
        check("hs second_writes", b_writes, 2);
        check("hs second_first_addr", b_first, 330);
        check("hs second_done_cycle", b_done, 2);
    endtask

    initial begin
        int exp4[4];
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp4[4];
        vecs[0] = '{x: 0,   y: 0,   w: 320, h: 180, color: 16'hF800, n: 57600, first: 0,     last: 57599};
        vecs[1] = '{x: 318, y: 178, w: 4,   h: 4,   color: 16'h07E0, n: 4,     first: 57278, last: 57599};
        vecs[2] = '{x: 10,  y: 10,  w: 0,   h: 5,   color: 16'h001F, n: 0,     first: 0,     last: 0};
        vecs[3] = '{x: 320, y: 0,   w: 4,   h: 4,   color: 16'h001F, n: 0,     first: 0,     last: 0};
        vecs[4] = '{x: 5,   y: 2,   w: 3,   h: 2,   color: 16'h1234, n: 6,     first: 645,   last: 967};
        vecs[5] = '{x: 0,   y: 179, w: 1,   h: 1,   color: 16'hABCD, n: 1,     first: 57280, last: 57280};
        vecs[6] = '{x: 319, y: 0,   w: 5,   h: 1,   color: 16'h5555, n: 1,     first: 319,   last: 319};
        exp4[0] = 57278; exp4[1] = 57279; exp4[2] = 57598; exp4[3] = 57599;

        step();
        step();
        check("reset ready", int'(cmd_ready), 1);
        check("reset we", int'(we), 0);
        check("reset done", int'(done), 0);
        check("reset swap", int'(swap), 0);
        check("reset addr", int'(waddr), 0);
        check("reset data", int'(wdata), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
                     vecs[i].n, vecs[i].first, vecs[i].last, $sformatf("vec%0d", i));
            if (i == 1) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("corner addr%0d", k),
                          (got_addr.size() > k) ? got_addr[k] : -1, exp4[k]);
                end
            end
        end

        run_swap();
        run_reset_mid_fill();
        run_handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_draw_engine.md
Name: fb_draw_engine

Overview:
- Write-side initiator for the double-buffered 320x180 RGB565 frame buffer.
- Accepts draw commands from the game CPU/command queue over a valid/ready handshake:
  - rectangle fill (clipped to screen);
  - buffer swap.
- Generates one pixel write per cycle on the frame buffer WRITE side.
- Issues swap_buffer only at a frame boundary, so displayed frames never tear.

Parameters:
- FB_WIDTH, 320, frame buffer width in pixels.
- FB_HEIGHT, 180, frame buffer height in pixels.
- FB_SIZE, $clog2(FB_WIDTH*FB_HEIGHT) (=16), localparam; write address width.
- X_W, $clog2(FB_WIDTH+1) (=9), localparam; x/width field width.
- Y_W, $clog2(FB_HEIGHT+1) (=8), localparam; y/height field width.

Ports:
- clk_in  input  1  system clock; also drives the frame buffer write clock.
- rst_in  input  1  synchronous active-high reset.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  engine can accept a command.
- cmd_op_in  input  1  0=FILL, 1=SWAP.
- cmd_x_in  input  X_W  rectangle left column.
- cmd_y_in  input  Y_W  rectangle top row.
- cmd_w_in  input  X_W  rectangle width.
- cmd_h_in  input  Y_W  rectangle height.
- cmd_color_in  input  16  RGB565 fill colour.
- vsync_in  input  1  single-cycle frame-start pulse, already in clk_in domain.
- cmd_done_out  output  1  single-cycle pulse when a command completes.
- write_data_out  output  16  pixel colour to frame buffer.
- write_addr_out  output  FB_SIZE  pixel address, y*FB_WIDTH+x.
- write_enable_out  output  1  single-cycle write strobe per pixel.
- swap_buffer_out  output  1  single-cycle buffer swap pulse.

Behaviour:
- Reset values: all outputs 0 except cmd_ready_out=1; state IDLE.
- Reset mid-fill or mid-wait:
  - operation is abandoned and no cmd_done_out is produced;
  - write_enable_out and swap_buffer_out are 0 on the cycle after rst_in is sampled high.
- All outputs are registered.
- States are IDLE, SETUP, FILL and WAIT_VSYNC.
- IDLE:
  - cmd_ready_out=1; a command is accepted when cmd_valid_in && cmd_ready_out;
  - all cmd_* fields are captured on that same cycle;
  - FILL opcode goes to SETUP; SWAP opcode goes to WAIT_VSYNC.
- SETUP (one cycle): clip the rectangle.
  - x_end = min(x+w, FB_WIDTH) and y_end = min(y+h, FB_HEIGHT), computed at X_W+1 / Y_W+1 bits so the sums cannot overflow.
  - Empty if w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT.
  - Empty: pulse cmd_done_out on the next cycle and return to IDLE with no writes.
  - Otherwise init cur_x=x, cur_y=y, row_base=y*FB_WIDTH (a single multiply here, or shift-add), then go to FILL.
- FILL: one write per cycle.
  - write_addr_out = row_base + cur_x, write_data_out = captured colour, write_enable_out=1.
  - Order is row-major: x increments; at x_end-1, cur_x reloads x, cur_y++ and row_base += FB_WIDTH.
  - The last write is at (x_end-1, y_end-1); cmd_done_out is asserted in the same cycle as that last write_enable_out; then IDLE.
- Fill latency: accepted at cycle T -> SETUP at T+1 -> first write at T+2. A fill of n pixels finishes at T+1+n.
- WAIT_VSYNC:
  - only a vsync_in sampled while in this state counts; a vsync coinciding with the accept cycle is ignored;
  - on vsync_in at cycle T, swap_buffer_out=1 and cmd_done_out=1 at T+1 for exactly one cycle, then IDLE.
- cmd_ready_out is 0 in every state except IDLE. Back-to-back commands therefore have at least one IDLE cycle between them.
- write_data_out and write_addr_out hold their last value when write_enable_out=0.

Decomposition:
- Package fb_draw_pkg holds:
  - FB_WIDTH and FB_HEIGHT constants;
  - typedef enum logic {OP_FILL, OP_SWAP} fb_op_t;
  - typedef enum of FSM states;
  - packed struct fb_cmd_t {op, x, y, w, h, color}.
- No sub-module. Clipping is small combinational logic inside SETUP.
- At top level, the outputs connect to frame_buffer_bus.WRITE, with write_clk tied to clk_in.

Test Plan:
- Full clear, FILL(0,0,320,180,0xF800):
  - exactly 57600 writes, addresses 0..57599 contiguous, data 0xF800;
  - cmd_done_out coincides with address 57599;
  - first write 2 cycles after accept.
- Clipped corner, FILL(318,178,4,4,0x07E0):
  - exactly 4 writes, in order 57278, 57279, 57598, 57599, then done.
- Empty commands FILL(10,10,0,5) and FILL(320,0,4,4):
  - zero writes each;
  - cmd_done_out exactly 2 cycles after accept (SETUP, then done pulse).
- SWAP:
  - accept with vsync_in pulsed on the accept cycle -> no swap;
  - vsync_in pulsed 50 cycles later -> swap_buffer_out and cmd_done_out high exactly 1 cycle, one cycle after that vsync.
- Reset mid-fill:
  - after 100 writes of a full clear, assert rst_in -> next cycle write_enable_out=0, cmd_ready_out=1, no cmd_done_out;
  - a subsequent 2x2 fill works normally.
- Handshake hold:
  - cmd_valid_in held high with two queued fills -> second accepted only after the first's cmd_done_out, with cmd_ready_out low throughout FILL.
